// File: rtl/bottle_fill_ctrl.sv
// Bottle filling controller: keypad entry of pill/bottle targets, run/pause/swap
// sequencing and the dispense strobe divider.
module bottle_fill_ctrl #(
  parameter int PILL_DIV = 4,
  parameter int SWAP_CYC = 8
) (
  input  logic       CLK,
  input  logic       RST_n,
  input  logic       btn_start,
  input  logic       btn_pause,
  input  logic       btn_set,
  input  logic       digit_valid,
  input  logic [3:0] digit,
  input  logic       bottle_done,
  input  logic       all_full,
  output logic [3:0] pill_l,
  output logic [3:0] pill_h,
  output logic [3:0] bot_l,
  output logic [3:0] bot_h,
  output logic       is_work,
  output logic       en_work,
  output logic       en_set,
  output logic       pill_pulse,
  output logic [2:0] state,
  output logic       alarm
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SET_PILL = 3'd1,
    S_SET_BOT  = 3'd2,
    S_RUN      = 3'd3,
    S_PAUSE    = 3'd4,
    S_SWAP     = 3'd5,
    S_DONE     = 3'd6
  } state_e;

  localparam logic [7:0] DIV_MAX   = 8'(PILL_DIV);
  localparam logic [7:0] SWAP_LAST = 8'(SWAP_CYC - 1);

  state_e     state_q, state_d;
  logic [3:0] pill_l_q, pill_l_d, pill_h_q, pill_h_d;
  logic [3:0] bot_l_q, bot_l_d, bot_h_q, bot_h_d;
  logic [7:0] div_q, div_d;
  logic [7:0] swap_q, swap_d;
  logic       is_work_q, is_work_d, en_work_q, en_work_d;
  logic       en_set_q, en_set_d, alarm_q, alarm_d;

  logic pill_nz, bot_nz, run_evt, digit_ok;

  assign pill_nz  = {pill_h_q, pill_l_q} != 8'd0;
  assign bot_nz   = {bot_h_q, bot_l_q} != 8'd0;
  assign run_evt  = all_full | bottle_done | btn_pause;
  assign digit_ok = digit_valid && (digit <= 4'd9);

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q   <= S_IDLE;
      pill_l_q  <= 4'd0;
      pill_h_q  <= 4'd0;
      bot_l_q   <= 4'd0;
      bot_h_q   <= 4'd0;
      div_q     <= 8'd0;
      swap_q    <= 8'd0;
      is_work_q <= 1'b0;
      en_work_q <= 1'b0;
      en_set_q  <= 1'b0;
      alarm_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pill_l_q  <= pill_l_d;
      pill_h_q  <= pill_h_d;
      bot_l_q   <= bot_l_d;
      bot_h_q   <= bot_h_d;
      div_q     <= div_d;
      swap_q    <= swap_d;
      is_work_q <= is_work_d;
      en_work_q <= en_work_d;
      en_set_q  <= en_set_d;
      alarm_q   <= alarm_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (btn_set) state_d = S_SET_PILL;
        else if (btn_start && pill_nz && bot_nz) state_d = S_RUN;
      end
      S_SET_PILL: if (btn_set && pill_nz) state_d = S_SET_BOT;
      S_SET_BOT:  if (btn_set && bot_nz) state_d = S_IDLE;
      S_RUN: begin
        if (all_full) state_d = S_DONE;
        else if (bottle_done) state_d = S_SWAP;
        else if (btn_pause) state_d = S_PAUSE;
      end
      S_PAUSE: begin
        if (all_full) state_d = S_DONE;
        else if (btn_start) state_d = S_RUN;
      end
      S_SWAP: begin
        if (all_full) state_d = S_DONE;
        else if (swap_q == SWAP_LAST) state_d = S_RUN;
      end
      S_DONE: if (btn_start) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Counters only advance while staying in their state, so every entry starts from zero.
  always_comb begin
    div_d    = 8'd0;
    swap_d   = 8'd0;
    pill_l_d = pill_l_q;
    pill_h_d = pill_h_q;
    bot_l_d  = bot_l_q;
    bot_h_d  = bot_h_q;
    if (state_q == S_RUN && state_d == S_RUN)
      div_d = (div_q == DIV_MAX) ? 8'd1 : div_q + 8'd1;
    if (state_q == S_SWAP && state_d == S_SWAP)
      swap_d = swap_q + 8'd1;
    if (state_q == S_SET_PILL && digit_ok) begin
      pill_h_d = pill_l_q;
      pill_l_d = digit;
    end
    if (state_q == S_SET_BOT && digit_ok) begin
      bot_h_d = bot_l_q;
      bot_l_d = digit;
    end
  end

  always_comb begin
    is_work_d  = (state_d == S_RUN) || (state_d == S_SWAP);
    en_work_d  = (state_d == S_RUN) || (state_d == S_SWAP) ||
                 (state_d == S_PAUSE) || (state_d == S_DONE);
    en_set_d   = (state_d == S_SET_PILL) || (state_d == S_SET_BOT);
    alarm_d    = (state_d == S_DONE);
    pill_pulse = (state_q == S_RUN) && (div_q == DIV_MAX) && !run_evt;
  end

  assign state   = state_q;
  assign pill_l  = pill_l_q;
  assign pill_h  = pill_h_q;
  assign bot_l   = bot_l_q;
  assign bot_h   = bot_h_q;
  assign is_work = is_work_q;
  assign en_work = en_work_q;
  assign en_set  = en_set_q;
  assign alarm   = alarm_q;

endmodule

// File: tb/tb_bottle_fill_ctrl.sv
// Directed and randomized bench for bottle_fill_ctrl against an arithmetic model
// of settings, pulse timing and state outcomes.
module tb_bottle_fill_ctrl;

  localparam int PILL_DIV = 4;
  localparam int SWAP_CYC = 8;

  logic       CLK = 1'b0;
  logic       RST_n;
  logic       btn_start, btn_pause, btn_set, digit_valid, bottle_done, all_full;
  logic [3:0] digit;
  logic [3:0] pill_l, pill_h, bot_l, bot_h;
  logic       is_work, en_work, en_set, pill_pulse, alarm;
  logic [2:0] state;

  int errors = 0;
  int checks = 0;
  int pill_m = 0;
  int bot_m  = 0;
  int since_run = 0;

  bottle_fill_ctrl #(.PILL_DIV(PILL_DIV), .SWAP_CYC(SWAP_CYC)) dut (
    .CLK(CLK), .RST_n(RST_n),
    .btn_start(btn_start), .btn_pause(btn_pause), .btn_set(btn_set),
    .digit_valid(digit_valid), .digit(digit),
    .bottle_done(bottle_done), .all_full(all_full),
    .pill_l(pill_l), .pill_h(pill_h), .bot_l(bot_l), .bot_h(bot_h),
    .is_work(is_work), .en_work(en_work), .en_set(en_set),
    .pill_pulse(pill_pulse), .state(state), .alarm(alarm)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    btn_start = 0; btn_pause = 0; btn_set = 0;
    digit_valid = 0; bottle_done = 0; all_full = 0;
  endtask

  task automatic check_settings(input string tag);
    chk({tag, "_pill_h"}, 32'(pill_h), 32'(pill_m / 10));
    chk({tag, "_pill_l"}, 32'(pill_l), 32'(pill_m % 10));
    chk({tag, "_bot_h"},  32'(bot_h),  32'(bot_m / 10));
    chk({tag, "_bot_l"},  32'(bot_l),  32'(bot_m % 10));
  endtask

  // Keypad entry: model keeps the last two accepted digits as a decimal number.
  task automatic press(input int d, input bit to_pill);
    digit_valid = 1; digit = 4'(d);
    tick();
    if (d <= 9) begin
      if (to_pill) pill_m = (pill_m % 10) * 10 + d;
      else         bot_m  = (bot_m % 10) * 10 + d;
    end
  endtask

  task automatic start_run(input string tag);
    btn_start = 1;
    tick();
    since_run = 0;
    chk({tag, "_state"}, 32'(state), 32'd3);
    chk({tag, "_is_work"}, 32'(is_work), 32'd1);
    chk({tag, "_pulse0"}, 32'(pill_pulse), 32'd0);
  endtask

  task automatic run_check(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      since_run++;
      chk("run_state", 32'(state), 32'd3);
      chk($sformatf("run_pulse_c%0d", since_run), 32'(pill_pulse),
          32'((since_run % PILL_DIV) == 0));
    end
  endtask

  // Enters SWAP via bottle_done and follows it back to RUN.
  task automatic swap_check(input int pause_at);
    bottle_done = 1;
    tick();
    chk("swap_enter", 32'(state), 32'd5);
    chk("swap_is_work", 32'(is_work), 32'd1);
    for (int k = 1; k <= SWAP_CYC; k++) begin
      chk("swap_pulse", 32'(pill_pulse), 32'd0);
      if (k == pause_at) btn_pause = 1;
      tick();
      chk($sformatf("swap_state_k%0d", k), 32'(state), (k < SWAP_CYC) ? 32'd5 : 32'd3);
    end
    since_run = 0;
  endtask

  task automatic finish_batch(input string tag);
    all_full = 1;
    tick();
    chk({tag, "_done"}, 32'(state), 32'd6);
    chk({tag, "_alarm"}, 32'(alarm), 32'd1);
    btn_start = 1;
    tick();
    chk({tag, "_idle"}, 32'(state), 32'd0);
    chk({tag, "_alarm_off"}, 32'(alarm), 32'd0);
  endtask

  initial begin
    RST_n = 0;
    btn_start = 0; btn_pause = 0; btn_set = 0;
    digit_valid = 0; digit = 4'd0; bottle_done = 0; all_full = 0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_state", 32'(state), 32'd0);
    check_settings("rst");
    chk("rst_outs", 32'({is_work, en_work, en_set, pill_pulse, alarm}), 32'd0);
    RST_n = 1;
    tick();

    // Zero settings refuse to start or advance.
    btn_start = 1; tick();
    chk("start_zero", 32'(state), 32'd0);
    btn_set = 1; tick();
    chk("set_pill", 32'(state), 32'd1);
    chk("en_set", 32'(en_set), 32'd1);
    btn_set = 1; tick();
    chk("set_pill_zero", 32'(state), 32'd1);

    press(2, 1); press(11, 1); press(5, 1);
    check_settings("pill25");
    btn_set = 1; tick();
    chk("set_bot", 32'(state), 32'd2);
    press(0, 0); press(3, 0);
    btn_set = 1; tick();
    chk("set_back_idle", 32'(state), 32'd0);
    chk("en_set_off", 32'(en_set), 32'd0);
    check_settings("p25_b03");

    digit_valid = 1; digit = 4'd7; tick();
    check_settings("idle_digit");

    btn_set = 1; btn_start = 1; tick();
    chk("set_over_start", 32'(state), 32'd1);
    btn_set = 1; tick();
    btn_set = 1; tick();
    chk("reidle", 32'(state), 32'd0);

    // Pulse cadence, swap, and gating of a due pulse by a same-cycle event.
    start_run("r1");
    run_check(13);
    swap_check(3);
    run_check(4);
    btn_pause = 1;
    #1;
    chk("pulse_gated", 32'(pill_pulse), 32'd0);
    tick();
    chk("pause_state", 32'(state), 32'd4);
    chk("pause_is_work", 32'(is_work), 32'd0);
    chk("pause_en_work", 32'(en_work), 32'd1);
    btn_pause = 1; tick();
    chk("pause_hold", 32'(state), 32'd4);
    start_run("resume");
    run_check(5);

    btn_pause = 1; bottle_done = 1; all_full = 1;
    tick();
    chk("prio_done", 32'(state), 32'd6);
    chk("prio_alarm", 32'(alarm), 32'd1);
    chk("done_is_work", 32'(is_work), 32'd0);
    chk("done_en_work", 32'(en_work), 32'd1);
    btn_pause = 1; tick();
    chk("done_hold", 32'(state), 32'd6);
    btn_start = 1; tick();
    chk("done_idle", 32'(state), 32'd0);
    chk("done_alarm_off", 32'(alarm), 32'd0);
    chk("idle_en_work", 32'(en_work), 32'd0);

    start_run("r2");
    run_check(1);
    bottle_done = 1; tick();
    tick(); tick();
    all_full = 1; tick();
    chk("swap_full", 32'(state), 32'd6);
    btn_start = 1; tick();
    check_settings("persist");

    // Randomized batches.
    for (int t = 0; t < 6; t++) begin
      int nd, ev, len;
      btn_set = 1; tick();
      nd = $urandom_range(1, 4);
      for (int i = 0; i < nd; i++) press($urandom_range(0, 12), 1);
      check_settings("rnd_pill");
      btn_set = 1; tick();
      chk("rnd_adv_pill", 32'(state), (pill_m != 0) ? 32'd2 : 32'd1);
      if (pill_m == 0) begin
        press($urandom_range(1, 9), 1);
        btn_set = 1; tick();
      end
      nd = $urandom_range(1, 4);
      for (int i = 0; i < nd; i++) press($urandom_range(0, 12), 0);
      check_settings("rnd_bot");
      btn_set = 1; tick();
      chk("rnd_adv_bot", 32'(state), (bot_m != 0) ? 32'd0 : 32'd2);
      if (bot_m == 0) begin
        press($urandom_range(1, 9), 0);
        btn_set = 1; tick();
      end
      start_run("rnd");
      len = $urandom_range(1, 15);
      run_check(len);
      ev = $urandom_range(0, 2);
      if (ev == 0) begin
        swap_check($urandom_range(1, SWAP_CYC));
        run_check(PILL_DIV);
      end else if (ev == 1) begin
        btn_pause = 1; tick();
        chk("rnd_pause", 32'(state), 32'd4);
        start_run("rnd_resume");
        run_check(PILL_DIV + 1);
      end
      finish_batch("rnd");
      check_settings("rnd_end");
    end

    // Asynchronous reset in the middle of a swap.
    start_run("r3");
    run_check(2);
    bottle_done = 1; tick();
    tick(); tick();
    #2;
    RST_n = 0;
    #1;
    pill_m = 0; bot_m = 0;
    chk("arst_state", 32'(state), 32'd0);
    check_settings("arst");
    chk("arst_outs", 32'({is_work, en_work, en_set, pill_pulse, alarm}), 32'd0);
    #2;
    RST_n = 1;
    tick();
    chk("post_rst", 32'(state), 32'd0);
    btn_start = 1; tick();
    chk("post_rst_start", 32'(state), 32'd0);
    chk("post_rst_pulse", 32'(pill_pulse), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bottle_fill_ctrl.md
BOTTLE_FILL_CTRL -- requirements
Module: bottle_fill_ctrl

Interface
REQ-001 SHALL have parameter PILL_DIV, default 4: CLK cycles between pill_pulse strobes in RUN (legal range 2..255).
REQ-002 SHALL have parameter SWAP_CYC, default 8: CLK cycles spent in SWAP per bottle change (legal range 1..255).
REQ-003 SHALL have port CLK  input  1  single system clock; all state updates on its rising edge.
REQ-004 SHALL have port RST_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port btn_start  input  1  one-cycle start/resume/acknowledge strobe.
REQ-006 SHALL have port btn_pause  input  1  one-cycle pause strobe.
REQ-007 SHALL have port btn_set  input  1  one-cycle setting-mode advance strobe.
REQ-008 SHALL have port digit_valid  input  1  qualifies digit for one cycle.
REQ-009 SHALL have port digit  input  4  BCD keypad digit.
REQ-010 SHALL have port bottle_done  input  1  one-cycle strobe from pill counter: current bottle full.
REQ-011 SHALL have port all_full  input  1  level from pill counter: bottle target reached.
REQ-012 SHALL have ports pill_l, pill_h  output  4 each  BCD pills-per-bottle setting (ones, tens).
REQ-013 SHALL have ports bot_l, bot_h  output  4 each  BCD bottle-count setting (ones, tens).
REQ-014 SHALL have ports is_work, en_work, en_set  output  1 each  counter control levels.
REQ-015 SHALL have port pill_pulse  output  1  one-cycle dispense strobe.
REQ-016 SHALL have ports state  output  3  current state code; alarm  output  1  batch-complete indicator.

Function
REQ-017 SHALL implement states IDLE=0, SET_PILL=1, SET_BOT=2, RUN=3, PAUSE=4, SWAP=5, DONE=6; code 7 unreachable, recovers to IDLE next cycle.
REQ-018 SHALL, in SET_PILL (SET_BOT), on digit_valid with digit<=9, shift pill_h<=pill_l, pill_l<=digit (bot_h/bot_l likewise); digit>9 ignored; digit_valid ignored in all other states.
REQ-019 SHALL transition IDLE->SET_PILL on btn_set; SET_PILL->SET_BOT on btn_set only if pill setting nonzero; SET_BOT->IDLE on btn_set only if bottle setting nonzero; zero setting leaves state unchanged.
REQ-020 SHALL transition IDLE->RUN on btn_start only if both settings nonzero; otherwise remain IDLE.
REQ-021 SHALL, in RUN, assert pill_pulse for one cycle every PILL_DIV cycles, first pulse PILL_DIV cycles after RUN entry; divider cleared on every RUN entry.
REQ-022 SHALL apply RUN priority all_full > bottle_done > btn_pause: all_full -> DONE; bottle_done -> SWAP; btn_pause -> PAUSE; no pill_pulse in the cycle any of these is sampled.
REQ-023 SHALL, in SWAP, hold pill_pulse low for exactly SWAP_CYC cycles then return to RUN; all_full in SWAP -> DONE immediately; btn_pause in SWAP ignored.
REQ-024 SHALL transition PAUSE->RUN on btn_start; all_full in PAUSE -> DONE.
REQ-025 SHALL transition DONE->IDLE on btn_start; alarm=1 exactly while in DONE.
REQ-026 SHALL drive is_work=1 in RUN and SWAP; en_work=1 in RUN, SWAP, PAUSE, DONE; en_set=1 in SET_PILL, SET_BOT; all registered, changing with state.
REQ-027 SHALL keep settings unchanged outside SET states; settings persist across batches.
REQ-028 SHALL ignore btn_start, btn_pause, btn_set in states where no transition is listed.
REQ-029 SHALL, with simultaneous btn_set and btn_start in IDLE, take btn_set.

Reset
REQ-030 SHALL, on RST_n low at any time (including mid-RUN/SWAP), asynchronously force state=IDLE, pill_l=pill_h=bot_l=bot_h=0, divider and swap counters 0, all 1-bit outputs 0.
REQ-031 SHALL resume normal operation on the first CLK edge after RST_n deasserts; no pill_pulse until a new RUN entry.

Verification
REQ-032 SHALL cover: btn_set, digits 2,5, btn_set, digits 0,3, btn_set -> pill=25, bot=03, state IDLE.
REQ-033 SHALL cover: settings 00, btn_start -> state stays 0; btn_set then btn_set with pill=00 -> stays SET_PILL.
REQ-034 SHALL cover: RUN with PILL_DIV=4 -> pill_pulse at cycles 4,8,12 after entry; bottle_done -> SWAP, 8 cycles no pulse, RUN, next pulse 4 cycles later.
REQ-035 SHALL cover: bottle_done, btn_pause and all_full same cycle in RUN -> DONE, alarm=1; btn_start -> IDLE, alarm=0.
REQ-036 SHALL cover: btn_pause in RUN -> PAUSE, is_work=0, en_work=1; btn_start -> RUN, divider restarted.
REQ-037 SHALL cover: RST_n low mid-SWAP, off-edge -> outputs zero immediately, state IDLE, settings 00.
